axi4_lite_mst_arbiter: RTL and testbench
========================================

Name: axi4_lite_mst_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ local requesters.
- Sits in front of AXI4-Lite register slaves such as the slave template; lets several control blocks (sequencers, test drivers) reach the same register file.
- One outstanding transaction at a time; round-robin grant; each requester uses a simple valid/ready command and a single-cycle response pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 4, AXI4-Lite address width
- DATA_W, 32, AXI4-Lite data width (32 or 64)

Ports:
- i_clk  in  1  clock
- i_sync_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_req_valid  in  NUM_REQ  command valid per requester
- o_req_ready  out  NUM_REQ  command accepted (one-hot, at most one bit set)
- i_req_we  in  NUM_REQ  1 = write, 0 = read
- i_req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
- i_req_wdata  in  NUM_REQ*DATA_W  packed write data
- i_req_wstrb  in  NUM_REQ*DATA_W/8  packed write strobes
- o_rsp_valid  out  NUM_REQ  one-hot response pulse
- o_rsp_rdata  out  DATA_W  read data; 0 for writes
- o_rsp_resp  out  2  BRESP or RRESP
- o_m_awaddr, o_m_awprot(3), o_m_awvalid, i_m_awready  AXI write-address channel
- o_m_wdata, o_m_wstrb, o_m_wvalid, i_m_wready  AXI write-data channel
- i_m_bresp(2), i_m_bvalid, o_m_bready  AXI write-response channel
- o_m_araddr, o_m_arprot(3), o_m_arvalid, i_m_arready  AXI read-address channel
- i_m_rdata, i_m_rresp(2), i_m_rvalid, o_m_rready  AXI read-data channel

Behaviour:
- Reset (i_sync_rst_n = 0 at a rising edge):
  - State IDLE; round-robin pointer = 0.
  - All o_m_*valid, o_m_bready, o_m_rready = 0; o_rsp_valid = 0; o_req_ready = 0.
  - Address, data and strobe outputs = 0.
- Reset mid-transaction: the next edge forces reset values and abandons the AXI transaction. The slave must be reset in the same cycle.
- State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - Winner = first requester with i_req_valid = 1, searching from the pointer upward with wrap-around.
  - o_req_ready[winner] = 1 combinationally in that cycle only.
  - Command is captured at the edge. Go to WR_REQ if i_req_we = 1, else RD_REQ.
  - No valid request: stay in IDLE.
- Requester rules: hold the command stable while valid is high until ready. Dropping valid before ready is illegal (bench asserts on it).
- WR_REQ:
  - o_m_awvalid and o_m_wvalid are both 1 from the first WR_REQ cycle.
  - Each drops independently, the edge after its own handshake.
  - Handshakes may occur in the same or different cycles.
  - When both have completed, go to WR_RESP.
- WR_RESP: o_m_bready = 1; on i_m_bvalid, capture i_m_bresp, set rdata = 0, go to RSP.
- RD_REQ: o_m_arvalid = 1 until i_m_arready, then go to RD_RESP.
- RD_RESP: o_m_rready = 1; on i_m_rvalid, capture i_m_rdata and i_m_rresp, go to RSP.
- RSP:
  - o_rsp_valid[granted] = 1 for exactly one cycle with the captured data and resp.
  - Pointer = (granted + 1) mod NUM_REQ.
  - Return to IDLE.
- Latency:
  - With a zero-wait slave, a write is accept at T, AW/W handshake at T+1, B at T+2, response at T+3.
  - A read is identical with AR/R in place of AW/W and B.
  - Next acceptance is no earlier than T+4.
- Fixed values: awprot = arprot = 3'b000.
- Addresses pass through unmodified, including unaligned addresses.
- Error responses (SLVERR/DECERR) are forwarded unchanged; no retry.
- No response backpressure; requesters must sample o_rsp_valid every cycle.

Optional Feature:
- Macro: AXI4_LITE_MST_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is not implemented and is treated as a constant 0.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Write, single requester: req0 write addr 0x0, data 0x12345678, wstrb 0xF.
  - AW/W with those values one cycle after ready; bresp 00.
  - o_rsp_valid = 0b01 with resp 00 three cycles after acceptance.
- Read: req1 reads 0x4 after 0x87654321 was written.
  - o_rsp_valid = 0b10, rdata 0x87654321, resp 00.
- Contention: req0 and req1 both request continuously for 4 transactions.
  - Grant order 0,1,0,1.
  - With AXI4_LITE_MST_ARB_FIXED_PRIO_EN defined: 0,0,0,0.
- Split handshake: awready delayed 3 cycles, wready immediate.
  - wvalid drops after 1 cycle, awvalid after 4.
  - bready asserted only after both handshakes; single response.
- Error: slave returns bresp 2'b10 on a write to 0xC -> o_rsp_resp = 2'b10.
- Reset mid-read: assert i_sync_rst_n = 0 while in RD_RESP.
  - Next edge: arvalid = rready = 0, no o_rsp_valid.
  - After release, a new request is granted to req0.

Source files
------------

// File: rtl/axi4_lite_mst_arbiter_if.sv
// AXI4-Lite master-side channel bundle for axi4_lite_mst_arbiter.
// The master modport is the arbiter side and the slave modport is the register-slave side.
interface axi4_lite_mst_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]     m_awaddr;
  logic [2:0]            m_awprot;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;
  logic [ADDR_W-1:0]     m_araddr;
  logic [2:0]            m_arprot;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_W-1:0]     m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rvalid;
  logic                  m_rready;

  modport master (
    output m_awaddr, m_awprot, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arprot, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    input  m_awaddr, m_awprot, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arprot, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/axi4_lite_mst_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ requesters, one transaction in flight.
// Define AXI4_LITE_MST_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module axi4_lite_mst_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                          i_clk,
  input  logic                          i_sync_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     i_req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] i_req_wstrb,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_W-1:0]             o_rsp_rdata,
  output logic [1:0]                    o_rsp_resp,
  axi4_lite_mst_arbiter_if.master       m_axi
);
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_s;
  logic [PTR_W-1:0]    grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic                aw_done_q, w_done_q;

  logic                win_found_s;
  logic [PTR_W-1:0]    win_idx_s, cand_s;
  logic [NUM_REQ-1:0]  win_onehot_s, grant_onehot_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [STRB_W-1:0]   sel_wstrb_s;
  logic                aw_ok_s, w_ok_s;
  logic                aw_valid_s, w_valid_s, b_ready_s, ar_valid_s, r_ready_s;

`ifdef AXI4_LITE_MST_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [PTR_W-1:0] ptr_q;

  // Round-robin pointer advances past the requester that just got its response.
  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      ptr_q <= '0;
    end else if (state_q == RSP) begin
      ptr_q <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end else begin
      ptr_q <= ptr_q;
    end
  end

  assign ptr_s = ptr_q;
`endif

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s      = PTR_W'((int'(ptr_s) + i) % NUM_REQ);
      win_idx_s   = (!win_found_s && i_req_valid[cand_s]) ? cand_s : win_idx_s;
      win_found_s = win_found_s | i_req_valid[cand_s];
    end
  end

  // Select the winning requester's command fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_wstrb_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_we_s    = sel_we_s    | ((win_idx_s == PTR_W'(k)) & i_req_we[k]);
      sel_addr_s  = sel_addr_s  | ((win_idx_s == PTR_W'(k)) ? i_req_addr[k*ADDR_W +: ADDR_W] : '0);
      sel_wdata_s = sel_wdata_s | ((win_idx_s == PTR_W'(k)) ? i_req_wdata[k*DATA_W +: DATA_W] : '0);
      sel_wstrb_s = sel_wstrb_s | ((win_idx_s == PTR_W'(k)) ? i_req_wstrb[k*STRB_W +: STRB_W] : '0);
    end
  end

  assign win_onehot_s   = NUM_REQ'(1) << win_idx_s;
  assign grant_onehot_s = NUM_REQ'(1) << grant_q;
  assign aw_ok_s        = aw_done_q | m_axi.m_awready;
  assign w_ok_s         = w_done_q  | m_axi.m_wready;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = win_found_s ? (sel_we_s ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  state_d = (aw_ok_s && w_ok_s) ? WR_RESP : WR_REQ;
      WR_RESP: state_d = m_axi.m_bvalid ? RSP : WR_RESP;
      RD_REQ:  state_d = m_axi.m_arready ? RD_RESP : RD_REQ;
      RD_RESP: state_d = m_axi.m_rvalid ? RSP : RD_RESP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode; AW and W valids drop independently once each handshake is recorded.
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    aw_valid_s  = 1'b0;
    w_valid_s   = 1'b0;
    b_ready_s   = 1'b0;
    ar_valid_s  = 1'b0;
    r_ready_s   = 1'b0;
    case (state_q)
      IDLE:    o_req_ready = win_found_s ? win_onehot_s : '0;
      WR_REQ: begin
        aw_valid_s = ~aw_done_q;
        w_valid_s  = ~w_done_q;
      end
      WR_RESP: b_ready_s   = 1'b1;
      RD_REQ:  ar_valid_s  = 1'b1;
      RD_RESP: r_ready_s   = 1'b1;
      RSP:     o_rsp_valid = grant_onehot_s;
      default: o_rsp_valid = '0;
    endcase
  end

  // Command capture, handshake tracking and response capture.
  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (win_found_s) begin
            grant_q <= win_idx_s;
            addr_q  <= sel_addr_s;
            wdata_q <= sel_wdata_s;
            wstrb_q <= sel_wstrb_s;
          end
        end
        WR_REQ: begin
          aw_done_q <= aw_ok_s;
          w_done_q  <= w_ok_s;
        end
        WR_RESP: begin
          if (m_axi.m_bvalid) begin
            resp_q  <= m_axi.m_bresp;
            rdata_q <= '0;
          end
        end
        RD_RESP: begin
          if (m_axi.m_rvalid) begin
            resp_q  <= m_axi.m_rresp;
            rdata_q <= m_axi.m_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_axi.m_awaddr  = addr_q;
  assign m_axi.m_awprot  = 3'b000;
  assign m_axi.m_awvalid = aw_valid_s;
  assign m_axi.m_wdata   = wdata_q;
  assign m_axi.m_wstrb   = wstrb_q;
  assign m_axi.m_wvalid  = w_valid_s;
  assign m_axi.m_bready  = b_ready_s;
  assign m_axi.m_araddr  = addr_q;
  assign m_axi.m_arprot  = 3'b000;
  assign m_axi.m_arvalid = ar_valid_s;
  assign m_axi.m_rready  = r_ready_s;
  assign o_rsp_rdata     = rdata_q;
  assign o_rsp_resp      = resp_q;
endmodule

// File: tb/tb_axi4_lite_mst_arbiter.sv
// Directed bench for axi4_lite_mst_arbiter with a small behavioural AXI4-Lite slave (4 words, configurable stalls).
module tb_axi4_lite_mst_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int n_checks = 0;
  int n_pass   = 0;

  // slave model controls and state
  int          aw_dly, w_dly;
  logic [1:0]  bresp_cfg;
  logic        r_block;
  logic        aw_got, w_got, bvalid_r, rvalid_r;
  logic [3:0]  aw_addr_l;
  logic [31:0] w_data_l, rdata_r;
  logic [31:0] mem [4];
  int          aw_cnt, w_cnt;

  always #5 clk = ~clk;

  axi4_lite_mst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ax ();

  axi4_lite_mst_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk        (clk),
    .i_sync_rst_n (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_wstrb  (req_wstrb),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_resp   (rsp_resp),
    .m_axi        (ax)
  );

  assign ax.m_awready = ax.m_awvalid && (aw_cnt >= aw_dly);
  assign ax.m_wready  = ax.m_wvalid && (w_cnt >= w_dly);
  assign ax.m_arready = ax.m_arvalid;
  assign ax.m_bvalid  = bvalid_r;
  assign ax.m_bresp   = bresp_cfg;
  assign ax.m_rvalid  = rvalid_r;
  assign ax.m_rdata   = rdata_r;
  assign ax.m_rresp   = 2'b00;

  // Slave: B is raised the edge both AW and W are done; R the edge after AR unless blocked.
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0;
    end else begin
      if (ax.m_awvalid && ax.m_awready) begin
        aw_got <= 1'b1; aw_cnt <= 0; aw_addr_l <= ax.m_awaddr;
      end else if (ax.m_awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (ax.m_wvalid && ax.m_wready) begin
        w_got <= 1'b1; w_cnt <= 0; w_data_l <= ax.m_wdata;
      end else if (ax.m_wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (bvalid_r && ax.m_bready) begin
        bvalid_r <= 1'b0;
      end else if (!bvalid_r && (aw_got || (ax.m_awvalid && ax.m_awready))
                             && (w_got || (ax.m_wvalid && ax.m_wready))) begin
        bvalid_r <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        mem[aw_got ? aw_addr_l[3:2] : ax.m_awaddr[3:2]] <= w_got ? w_data_l : ax.m_wdata;
      end
      if (rvalid_r && ax.m_rready) begin
        rvalid_r <= 1'b0;
      end else if (ax.m_arvalid && ax.m_arready && !r_block) begin
        rvalid_r <= 1'b1;
        rdata_r  <= mem[ax.m_araddr[3:2]];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One complete transaction from requester k; reports latency from acceptance and AW/W activity.
  task automatic run_txn(input int k, input logic we, input logic [3:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws,
                         output logic [1:0] rsp_v, output logic [31:0] rd, output logic [1:0] rs,
                         output int lat, output int aw_cyc, output int w_cyc, output bit b_early);
    bit got;
    rsp_v = 2'b00; rd = 32'h0; rs = 2'b00; lat = 0; aw_cyc = 0; w_cyc = 0; b_early = 1'b0; got = 1'b0;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k*4 +: 4]   = addr;
    req_wdata[k*32 +: 32] = wd;
    req_wstrb[k*4 +: 4]  = ws;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_ready[k]) got = 1'b1;
      else @(negedge clk);
    end
    check_val("accept", 64'(got), 64'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      #1;
      if (ax.m_awvalid) aw_cyc++;
      if (ax.m_wvalid) w_cyc++;
      if (ax.m_bready && (ax.m_awvalid || ax.m_wvalid)) b_early = 1'b1;
      if (rsp_valid != 2'b00) begin
        got = 1'b1; lat = i; rsp_v = rsp_valid; rd = rsp_rdata; rs = rsp_resp;
      end else begin
        @(negedge clk);
      end
    end
    check_val("rsp_seen", 64'(got), 64'd1);
    @(negedge clk);
    #1;
    check_val("rsp_single", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0]  rv, rs;
    logic [31:0] rd;
    int          lat, awc, wc, n;
    bit          be, got;
    logic [1:0]  g [4];
    logic [1:0]  g_exp [4];

    rst_n = 1'b0; req_valid = 2'b00; req_we = 2'b00; req_addr = 8'h00;
    req_wdata = 64'h0; req_wstrb = 8'h00;
    aw_dly = 0; w_dly = 0; bresp_cfg = 2'b00; r_block = 1'b0;
    g[0] = 2'b00; g[1] = 2'b00; g[2] = 2'b00; g[3] = 2'b00;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_valids", 64'({ax.m_awvalid, ax.m_wvalid, ax.m_arvalid}), 64'd0);
    check_val("rst_readies", 64'({ax.m_bready, ax.m_rready}), 64'd0);
    check_val("rst_awaddr", 64'(ax.m_awaddr), 64'd0);
    check_val("rst_wdata", 64'(ax.m_wdata), 64'd0);
    check_val("rst_wstrb", 64'(ax.m_wstrb), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single write from req0, cycle by cycle
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b01; req_addr = 8'h00;
    req_wdata = 64'h0000_0000_1234_5678; req_wstrb = 8'h0F;
    #1 check_val("wr_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_val("wr_awvalid_wvalid", 64'({ax.m_awvalid, ax.m_wvalid}), 64'd3);
    check_val("wr_awaddr", 64'(ax.m_awaddr), 64'd0);
    check_val("wr_wdata", 64'(ax.m_wdata), 64'h1234_5678);
    check_val("wr_wstrb", 64'(ax.m_wstrb), 64'hF);
    check_val("wr_awprot", 64'(ax.m_awprot), 64'd0);
    @(negedge clk);
    #1;
    check_val("wr_bready", 64'({ax.m_bready, ax.m_awvalid, ax.m_wvalid}), 64'd4);
    @(negedge clk);
    #1;
    check_val("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check_val("wr_rsp_resp", 64'(rsp_resp), 64'd0);
    check_val("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    #1 check_val("wr_rsp_gone", 64'(rsp_valid), 64'd0);

    // write 0x87654321 to 0x4 via req0, read back via req1
    run_txn(0, 1'b1, 4'h4, 32'h8765_4321, 4'hF, rv, rd, rs, lat, awc, wc, be);
    check_val("w4_rsp_valid", 64'(rv), 64'd1);
    check_val("w4_latency", 64'(lat), 64'd3);
    run_txn(1, 1'b0, 4'h4, 32'h0, 4'h0, rv, rd, rs, lat, awc, wc, be);
    check_val("rd_rsp_valid", 64'(rv), 64'd2);
    check_val("rd_rdata", 64'(rd), 64'h8765_4321);
    check_val("rd_resp", 64'(rs), 64'd0);
    check_val("rd_latency", 64'(lat), 64'd3);

    // contention: both requesters hold valid for four grants (pointer is 0 here)
`ifdef AXI4_LITE_MST_ARB_FIXED_PRIO_EN
    g_exp[0] = 2'b01; g_exp[1] = 2'b01; g_exp[2] = 2'b01; g_exp[3] = 2'b01;
`else
    g_exp[0] = 2'b01; g_exp[1] = 2'b10; g_exp[2] = 2'b01; g_exp[3] = 2'b10;
`endif
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_addr = 8'h44;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        g[n] = req_ready;
        n++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (6) @(negedge clk);
    check_val("cont_grants", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) check_val($sformatf("cont_grant%0d", i), 64'(g[i]), 64'(g_exp[i]));

    // split handshake: AW stalled three cycles, W immediate
    aw_dly = 3;
    run_txn(0, 1'b1, 4'h8, 32'hA5A5_A5A5, 4'hF, rv, rd, rs, lat, awc, wc, be);
    aw_dly = 0;
    check_val("split_awvalid_cycles", 64'(awc), 64'd4);
    check_val("split_wvalid_cycles", 64'(wc), 64'd1);
    check_val("split_bready_early", 64'(be), 64'd0);
    check_val("split_latency", 64'(lat), 64'd6);
    check_val("split_rsp_valid", 64'(rv), 64'd1);

    // SLVERR forwarded on a write to 0xC
    bresp_cfg = 2'b10;
    run_txn(0, 1'b1, 4'hC, 32'hDEAD_BEEF, 4'hF, rv, rd, rs, lat, awc, wc, be);
    bresp_cfg = 2'b00;
    check_val("err_resp", 64'(rs), 64'd2);
    check_val("err_rsp_valid", 64'(rv), 64'd1);

    // reset while stuck in RD_RESP (req1 read, slave withholds R)
    r_block = 1'b1;
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b00; req_addr = 8'h00;
    #1 check_val("rr_ready", 64'(req_ready), 64'd2);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check_val("rr_arvalid", 64'(ax.m_arvalid), 64'd1);
    @(negedge clk);
    #1 check_val("rr_rready", 64'(ax.m_rready), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_val("rr_after_rst", 64'({ax.m_arvalid, ax.m_rready, rsp_valid}), 64'd0);
    rst_n = 1'b1;
    r_block = 1'b0;
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_addr = 8'h44;
    #1 check_val("rr_regrant_req0", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      #1;
      if (rsp_valid != 2'b00) got = 1'b1;
      else @(negedge clk);
    end
    check_val("rr_post_rsp_valid", 64'(rsp_valid), 64'd1);
    check_val("rr_post_rdata", 64'(rsp_rdata), 64'h8765_4321);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
